// File: rtl/sample_pwm_player.sv
// sample_pwm_player: 8-bit PWM audio player that requests one sample per 256-cycle period
// and double-buffers the duty so that only whole periods are ever played.
module sample_pwm_player #(
  parameter logic [7:0] RESET_DUTY = 8'd128
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       enable,
  input  logic       done,
  input  logic [7:0] sample,
  input  logic       clr_overrun,
  output logic       sample_now,
  output logic       pwm_out,
  output logic [7:0] duty,
  output logic       overrun
);
  typedef enum logic {ST_IDLE, ST_WAIT} state_t;
  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d, act_q, act_d, pend_q, pend_d;
  logic       req_q, req_d, pwm_q, pwm_d, ovr_q, ovr_d;
  logic       wrap, take;
  always_comb begin
    wrap    = enable && cnt_q == 8'hFF;
    take    = done && state_q == ST_WAIT;
    cnt_d   = enable ? cnt_q + 8'd1 : 8'd0;
    state_d = !enable ? ST_IDLE : wrap ? ST_WAIT : take ? ST_IDLE : state_q;
    req_d   = wrap;
    act_d   = wrap ? pend_q : act_q;
    pend_d  = take ? sample : pend_q;
    // A wrap that finds the previous request still outstanding is an overrun, and beats a clear.
    ovr_d   = (wrap && state_q == ST_WAIT && !done) ? 1'b1 : clr_overrun ? 1'b0 : ovr_q;
    pwm_d   = enable && (cnt_q < act_q);
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      req_q   <= 1'b0;
      pwm_q   <= 1'b0;
      ovr_q   <= 1'b0;
      act_q   <= RESET_DUTY;
      pend_q  <= RESET_DUTY;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      pwm_q   <= pwm_d;
      ovr_q   <= ovr_d;
      act_q   <= act_d;
      pend_q  <= pend_d;
    end
  end
  assign sample_now = req_q;
  assign pwm_out    = pwm_q;
  assign duty       = act_q;
  assign overrun    = ovr_q;
endmodule

// File: tb/tb_sample_pwm_player.sv
// tb_sample_pwm_player: period-level vectors for the PWM player; expected duties are queued
// when a period's stimulus is issued and popped when the DUT raises sample_now.
module tb_sample_pwm_player;
  logic       clk = 1'b0, n_rst = 1'b0, enable = 1'b0, done = 1'b0, clr_overrun = 1'b0;
  logic [7:0] sample = 8'd0;
  logic       sample_now, pwm_out, overrun;
  logic [7:0] duty;

  always #5 clk = ~clk;

  sample_pwm_player #(.RESET_DUTY(8'd128)) dut (
    .clk(clk), .n_rst(n_rst), .enable(enable), .done(done), .sample(sample),
    .clr_overrun(clr_overrun), .sample_now(sample_now), .pwm_out(pwm_out),
    .duty(duty), .overrun(overrun)
  );

  typedef struct {
    bit         do_done;
    int         dly;
    logic [7:0] s;
    int         dly2;
    int         clr_at;
    int         exp_hi;
    logic [7:0] exp_duty;
    bit         exp_ovr;
  } vec_t;

  vec_t       tbl[13];
  int         checks = 0, errors = 0;
  int         hi, pulses, cyc, last_pulse;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear();
    hi = 0; pulses = 0; cyc = 0; last_pulse = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    hi += int'(pwm_out);
    if (sample_now) begin
      pulses++;
      last_pulse = cyc;
      if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
      else chk("duty_sb", int'(duty), int'(exp_q.pop_front()));
    end
  endtask

  initial begin
    tbl[0]  = '{1, 5,   8'h40, 0,  0,   128, 8'h40, 0};
    tbl[1]  = '{1, 5,   8'h00, 0,  0,   64,  8'h00, 0};
    tbl[2]  = '{1, 5,   8'hFF, 0,  0,   0,   8'hFF, 0};
    tbl[3]  = '{1, 0,   8'h80, 0,  0,   255, 8'h80, 0};
    tbl[4]  = '{0, 0,   8'h00, 0,  0,   128, 8'h80, 1};
    tbl[5]  = '{1, 10,  8'h20, 0,  0,   128, 8'h20, 1};
    tbl[6]  = '{1, 5,   8'h60, 0,  100, 32,  8'h60, 0};
    tbl[7]  = '{1, 255, 8'hC0, 0,  0,   96,  8'h60, 0};
    tbl[8]  = '{0, 0,   8'h00, 0,  0,   96,  8'hC0, 1};
    tbl[9]  = '{1, 5,   8'h30, 50, 100, 192, 8'h30, 0};
    tbl[10] = '{0, 0,   8'h00, 0,  255, 48,  8'h30, 1};
    tbl[11] = '{1, 5,   8'hFF, 0,  100, 48,  8'hFF, 0};
    tbl[12] = '{1, 5,   8'h80, 0,  0,   255, 8'h80, 0};

    repeat (3) @(negedge clk);
    chk("rst_sample_now", int'(sample_now), 0);
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_duty", int'(duty), 128);
    chk("rst_overrun", int'(overrun), 0);
    n_rst = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    exp_q.push_back(8'd128);
    clear();
    for (int i = 1; i <= 256; i++) tick();
    chk("first_hi", hi, 128);
    chk("first_pulses", pulses, 1);
    chk("first_pulse_pos", last_pulse, 256);

    for (int r = 0; r < 13; r++) begin
      exp_q.push_back(tbl[r].exp_duty);
      clear();
      done   = tbl[r].do_done && tbl[r].dly == 0;
      sample = tbl[r].s;
      for (int i = 1; i <= 256; i++) begin
        tick();
        done        = (tbl[r].do_done && i == tbl[r].dly) || (tbl[r].dly2 != 0 && i == tbl[r].dly2);
        sample      = (tbl[r].dly2 != 0 && i == tbl[r].dly2) ? 8'hAA : tbl[r].s;
        clr_overrun = tbl[r].clr_at != 0 && i == tbl[r].clr_at;
      end
      chk($sformatf("hi_row%0d", r), hi, tbl[r].exp_hi);
      chk($sformatf("pulses_row%0d", r), pulses, 1);
      chk($sformatf("pulse_pos_row%0d", r), last_pulse, 256);
      chk($sformatf("overrun_row%0d", r), int'(overrun), int'(tbl[r].exp_ovr));
    end

    clear();
    for (int i = 1; i <= 100; i++) begin
      tick();
      done   = i == 5;
      sample = 8'h11;
    end
    enable = 1'b0;
    tick();
    chk("dis_pwm", int'(pwm_out), 0);
    chk("dis_sample_now", int'(sample_now), 0);
    clear();
    repeat (300) tick();
    chk("dis_hi", hi, 0);
    chk("dis_pulses", pulses, 0);
    chk("dis_duty", int'(duty), 8'h80);

    enable = 1'b1;
    exp_q.push_back(8'h11);
    clear();
    for (int i = 1; i <= 256; i++) tick();
    chk("reen_hi", hi, 128);
    chk("reen_pulses", pulses, 1);
    chk("reen_pulse_pos", last_pulse, 256);

    exp_q.push_back(8'h11);
    clear();
    for (int i = 1; i <= 256; i++) tick();
    chk("pre_rst_hi", hi, 17);
    chk("pre_rst_overrun", int'(overrun), 1);

    repeat (3) tick();
    #1 n_rst = 1'b0;
    #1;
    chk("arst_duty", int'(duty), 128);
    chk("arst_overrun", int'(overrun), 0);
    chk("arst_sample_now", int'(sample_now), 0);
    chk("arst_pwm", int'(pwm_out), 0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    exp_q.push_back(8'd128);
    clear();
    for (int i = 1; i <= 300 && pulses == 0; i++) begin
      tick();
      done   = i == 3;
      sample = 8'h55;
    end
    done = 1'b0;
    chk("post_rst_pulses", pulses, 1);
    chk("post_rst_pulse_pos", last_pulse, 256);
    chk("post_rst_overrun", int'(overrun), 0);
    chk("sb_left", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
